output_port: RTL and testbench
==============================

// Module: output_port
// PURPOSE
//   Buffers words emitted by the CPU's OUT instruction and drains them to an external
//   consumer over a valid/ready stream.
//   - Input side: captures the 16-bit source-register value whenever the control unit
//     pulses output_valid. The CPU never stalls.
//   - Output side: presents buffered words in order; optionally serialises each word
//     into two bytes.
//   - If a word arrives while the buffer is full, it is dropped and a sticky overflow
//     flag is raised.
// PARAMETERS
//   DEPTH   8   FIFO entries; must be a power of 2 and >= 2
// PORTS
//   clk            in   1    system clock; all logic on posedge clk
//   rst_n          in   1    reset; synchronous and active-low
//   output_valid   in   1    one-cycle pulse from control_unit EXECUTE of OUT
//   out_data       in   16   register-file A-port value sampled with output_valid
//   ovf_clr        in   1    clears the sticky overflow flag
//   port_valid     out  1    head beat available to the consumer
//   port_ready     in   1    consumer accepts the beat when port_valid && port_ready
//   port_data      out  PW   beat data; PW = 8 with OUTPUT_PORT_BYTE_EN, else 16
//   port_last      out  1    current beat is the final beat of its word
//   fifo_full      out  1    count == DEPTH
//   fifo_empty     out  1    count == 0
//   overflow       out  1    sticky; a word was dropped
// BEHAVIOUR
//   - Reset (synchronous, rst_n low at posedge):
//     - wr_ptr, rd_ptr, count, beat index and overflow are cleared to 0.
//     - After reset: port_valid=0, fifo_empty=1, fifo_full=0, port_last=0, port_data=0.
//     - Storage array is not reset.
//     - Reset mid-transfer discards all words, including any partially sent word.
//   - Push: output_valid && !fifo_full at a clock edge writes out_data at wr_ptr.
//     wr_ptr then increments mod DEPTH.
//   - Drop: output_valid && fifo_full. fifo_full is the pre-edge value, so a pop in
//     the same cycle does not make room. The word is discarded and overflow is set on
//     the next edge.
//   - overflow: ovf_clr clears it. If a drop and ovf_clr occur in the same cycle,
//     set wins.
//   - Read side:
//     - port_valid = !fifo_empty.
//     - port_data and port_last are driven combinationally from the head entry and the
//       beat index.
//     - Latency: a word pushed at edge N is presented from edge N onward, i.e. visible
//       in cycle N+1.
//   - Stability: while port_valid && !port_ready, port_data and port_last hold
//     (unless reset).
//   - Pop: the head word leaves (rd_ptr++ mod DEPTH) when its last beat is accepted.
//   - Push and pop in the same cycle: count is unchanged and both pointers advance.
//   - Count: width $clog2(DEPTH)+1, so the full state is unambiguous. Pointers wrap
//     naturally at DEPTH.
//   - Beat FSM (byte mode only): states BEAT_HI and BEAT_LO.
//     - BEAT_HI: port_data = head[15:8], port_last=0. On accept, go to BEAT_LO.
//     - BEAT_LO: port_data = head[7:0], port_last=1. On accept, pop the word and go
//       to BEAT_HI.
//     - The FSM only moves on an accepted beat; it idles in BEAT_HI while empty.
// CONFIGURATION
//   OUTPUT_PORT_BYTE_EN defined: 8-bit port with the two-beat serialisation above.
//   OUTPUT_PORT_BYTE_EN undefined:
//     - 16-bit port; port_data = head word, port_last = port_valid.
//     - Each accept pops one word; no beat FSM is instantiated.
// STRUCTURE
//   - turtle_io_pkg: localparam CPU_DATA_W=16; typedef enum logic {BEAT_HI, BEAT_LO}
//     beat_t.
//   - Sub-module sync_fifo (DEPTH, WIDTH=16):
//     - ports: push, din, pop, dout(head), full, empty.
//     - It holds pointers and count.
//   - output_port adds the drop/overflow logic and the beat FSM.
// TESTING
//   1. Reset, then out_data=16'hA5C3 with output_valid, port_ready=1.
//      - Without BYTE_EN: 1 beat of 16'hA5C3, last=1.
//      - With BYTE_EN: 8'hA5 (last=0), then 8'hC3 (last=1); then fifo_empty=1.
//   2. Hold port_ready=0 and push 0x0001..0x0008.
//      - fifo_full=1.
//      - A 9th push of 0x0009 is dropped: overflow=1 next cycle.
//      - Drain with port_ready=1: exactly 0x0001..0x0008 in order.
//   3. Full FIFO; the same cycle has output_valid plus the final accept of the head.
//      - The head is popped and the new word is dropped; overflow=1.
//      - Repeat with ovf_clr=1 in that cycle: overflow is still 1.
//   4. Toggle port_ready randomly over 20 pushes of 0x1000+i.
//      - port_data is stable on every stalled cycle.
//      - Output sequence equals input sequence.
//   5. Byte mode: after the 8'hA5 beat of 16'hA5C3 is accepted, pulse rst_n=0.
//      - Next cycle: port_valid=0, fifo_empty=1.
//      - A new push of 16'h1234 emits 8'h12 first.
//   6. Pointer wrap over 3*DEPTH words with simultaneous push/pop every cycle.
//      - Count stays constant; no loss and no overflow.

Source files
------------

// File: rtl/turtle_io_pkg.sv
// Shared types and widths for the CPU output port.
// The port width follows OUTPUT_PORT_BYTE_EN: 8-bit beats when defined, whole 16-bit words otherwise.
package turtle_io_pkg;

    localparam int CPU_DATA_W = 16;

`ifdef OUTPUT_PORT_BYTE_EN
    localparam int PORT_W = 8;
`else
    localparam int PORT_W = CPU_DATA_W;
`endif

    typedef enum logic {BEAT_HI, BEAT_LO} beat_t;

endpackage

// File: rtl/output_port_if.sv
// Valid/ready stream carrying output-port beats to the external consumer.
// The beat width tracks OUTPUT_PORT_BYTE_EN through turtle_io_pkg::PORT_W.
interface output_port_if import turtle_io_pkg::*; ();

    logic              port_valid;
    logic              port_ready;
    logic [PORT_W-1:0] port_data;
    logic              port_last;

    modport master (output port_valid, port_data, port_last, input port_ready);
    modport slave  (input port_valid, port_data, port_last, output port_ready);

endinterface

// File: rtl/output_port_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head.
// A push is ignored when the FIFO is full, and a pop is ignored when it is empty.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/output_port.sv
// CPU OUT-instruction buffer: captures words, drops them with a sticky overflow when full, and drains them to a stream.
// With OUTPUT_PORT_BYTE_EN defined, each word is sent high byte first as two beats.
module output_port import turtle_io_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  output_valid,
    input  logic [CPU_DATA_W-1:0] out_data,
    input  logic                  ovf_clr,
    output_port_if.master         port,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  overflow
);

    logic [CPU_DATA_W-1:0] head;
    logic                  pop;
    logic                  accept;
    logic                  drop;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(CPU_DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (output_valid),
        .din   (out_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign port.port_valid = !fifo_empty;
    assign accept          = port.port_valid && port.port_ready;
    // Full is the pre-edge value, so a pop in the same cycle does not make room.
    assign drop            = output_valid && fifo_full;

    // A drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

`ifdef OUTPUT_PORT_BYTE_EN
    beat_t beat_q;
    beat_t beat_d;

    always_ff @(posedge clk) begin
        if (!rst_n) beat_q <= BEAT_HI;
        else        beat_q <= beat_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        beat_d         = beat_q;
        pop            = 1'b0;
        port.port_data = '0;
        port.port_last = 1'b0;
        if (port.port_valid) begin
            case (beat_q)
                BEAT_HI: begin
                    port.port_data = head[15:8];
                    if (accept) beat_d = BEAT_LO;
                end
                BEAT_LO: begin
                    port.port_data = head[7:0];
                    port.port_last = 1'b1;
                    if (accept) begin
                        pop    = 1'b1;
                        beat_d = BEAT_HI;
                    end
                end
                default: beat_d = BEAT_HI;
            endcase
        end
    end
`else
    assign port.port_data = fifo_empty ? '0 : head;
    assign port.port_last = port.port_valid;
    assign pop            = accept;
`endif

endmodule

// File: tb/tb_output_port.sv
// Directed bench for output_port; works with or without OUTPUT_PORT_BYTE_EN.
module tb_output_port;
    import turtle_io_pkg::*;

    localparam int DEPTH = 8;
    localparam int BEATS = (PORT_W == 8) ? 2 : 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        output_valid;
    logic [15:0] out_data;
    logic        ovf_clr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;

    output_port_if port_if ();

    output_port #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .output_valid (output_valid),
        .out_data     (out_data),
        .ovf_clr      (ovf_clr),
        .port         (port_if),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] beat_of(input logic [15:0] w, input int b);
        if (BEATS == 2) return (b == 0) ? {24'h0, w[15:8]} : {24'h0, w[7:0]};
        return {16'h0, w};
    endfunction

    task automatic push_word(input logic [15:0] w);
        output_valid = 1'b1;
        out_data     = w;
        tick();
        output_valid = 1'b0;
    endtask

    task automatic take_word(input string tag, input logic [15:0] w);
        port_if.port_ready = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            check({tag, "_valid"}, port_if.port_valid, 1);
            check({tag, "_data"}, port_if.port_data, beat_of(w, b));
            check({tag, "_last"}, port_if.port_last, (b == BEATS - 1));
            tick();
        end
        port_if.port_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        output_valid = 1'b0;
        ovf_clr      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] w;
        logic        rdy;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        int          pushed;
        int          popped;
        int          beat;
        int          cycles;
        int          occ;

        rst_n              = 1'b0;
        output_valid       = 1'b0;
        out_data           = '0;
        ovf_clr            = 1'b0;
        port_if.port_ready = 1'b0;
        @(negedge clk);

        // 1: reset state, then a single word
        do_reset();
        check("rst_valid", port_if.port_valid, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_last", port_if.port_last, 0);
        check("rst_data", port_if.port_data, 0);
        check("rst_ovf", overflow, 0);
        port_if.port_ready = 1'b1;
        push_word(16'hA5C3);
        take_word("t1", 16'hA5C3);
        check("t1_empty", fifo_empty, 1);

        // 2: fill, drop the ninth word, drain in order
        for (int i = 1; i <= DEPTH; i++) push_word(16'(i));
        check("t2_full", fifo_full, 1);
        check("t2_ovf_before", overflow, 0);
        push_word(16'h0009);
        check("t2_ovf_after", overflow, 1);
        for (int i = 1; i <= DEPTH; i++) take_word("t2_drain", 16'(i));
        check("t2_empty", fifo_empty, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t2_ovf_clr", overflow, 0);

        // 3: drop on the same cycle as the final accept of the head
        for (int i = 1; i <= DEPTH; i++) push_word(16'h0100 + 16'(i));
        if (BEATS == 2) begin
            port_if.port_ready = 1'b1;
            tick();
        end
        port_if.port_ready = 1'b1;
        push_word(16'hBEEF);
        port_if.port_ready = 1'b0;
        check("t3_ovf", overflow, 1);
        check("t3_not_full", fifo_full, 0);
        check("t3_head", port_if.port_data, beat_of(16'h0102, 0));
        push_word(16'h0109);
        check("t3_refull", fifo_full, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_cleared", overflow, 0);
        if (BEATS == 2) begin
            port_if.port_ready = 1'b1;
            tick();
        end
        port_if.port_ready = 1'b1;
        ovf_clr            = 1'b1;
        push_word(16'hDEAD);
        ovf_clr            = 1'b0;
        port_if.port_ready = 1'b0;
        check("t3_set_wins", overflow, 1);
        for (int i = 3; i <= 9; i++) take_word("t3_drain", 16'h0100 + 16'(i));
        check("t3_empty", fifo_empty, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // 4: random back-pressure over 20 words
        exp_q.delete();
        pushed     = 0;
        popped     = 0;
        beat       = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        while (popped < 20 && cycles < 2000) begin
            occ = pushed - popped;
            if (prev_stall) begin
                check("t4_stable_data", port_if.port_data, prev_data);
                check("t4_stable_last", port_if.port_last, prev_last);
            end
            rdy                = 1'($urandom_range(0, 1));
            port_if.port_ready = rdy;
            if (port_if.port_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("t4_spurious_beat", 1, 0);
                end else begin
                    check("t4_beat", port_if.port_data, beat_of(exp_q[0], beat));
                    check("t4_last", port_if.port_last, (beat == BEATS - 1));
                    if (beat == BEATS - 1) begin
                        void'(exp_q.pop_front());
                        popped++;
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end
            prev_stall = port_if.port_valid && !rdy;
            prev_data  = 32'(port_if.port_data);
            prev_last  = port_if.port_last;
            output_valid = 1'b0;
            if (pushed < 20 && occ < DEPTH && $urandom_range(0, 1) == 1) begin
                w            = 16'h1000 + 16'(pushed);
                output_valid = 1'b1;
                out_data     = w;
                exp_q.push_back(w);
                pushed++;
            end
            tick();
            cycles++;
        end
        output_valid       = 1'b0;
        port_if.port_ready = 1'b0;
        check("t4_words", popped, 20);
        check("t4_ovf", overflow, 0);
        check("t4_empty", fifo_empty, 1);

        // 5: reset in the middle of a word
        push_word(16'hA5C3);
        push_word(16'h5A5A);
        port_if.port_ready = 1'b1;
        tick();
        port_if.port_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_valid", port_if.port_valid, 0);
        check("t5_empty", fifo_empty, 1);
        check("t5_data", port_if.port_data, 0);
        push_word(16'h1234);
        take_word("t5_new", 16'h1234);
        check("t5_empty_after", fifo_empty, 1);

        // 6: pointer wrap with push and pop on the same edge
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            w = 16'h2F00 + 16'(i);
            push_word(w);
            exp_q.push_back(w);
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            for (int b = 0; b < BEATS; b++) begin
                output_valid       = (b == BEATS - 1);
                out_data           = 16'h2000 + 16'(i);
                port_if.port_ready = 1'b1;
                check("t6_beat", port_if.port_data, beat_of(exp_q[0], b));
                check("t6_not_empty", fifo_empty, 0);
                if (b == BEATS - 1) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(out_data);
                end
                tick();
            end
        end
        output_valid       = 1'b0;
        port_if.port_ready = 1'b0;
        check("t6_ovf", overflow, 0);
        check("t6_not_full", fifo_full, 0);
        for (int k = 0; k < 4; k++) take_word("t6_drain", exp_q.pop_front());
        check("t6_empty", fifo_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
